apa102_out: RTL and testbench

APA102_OUT -- requirements
Module: apa102_out

---
 rtl/apa102_out.sv | 140 ++++++++++++++
 tb/tb_apa102_out.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/apa102_out.sv
// APA102 LED strip driver: serialises a start frame, LED_CNT pixel frames and an end frame
// onto sck/sda from a shadow copy of the pixel data captured at the start of each transfer.
module apa102_out #(
  parameter int         LED_CNT    = 7,
  parameter int         CLK_DIV    = 2,
  parameter logic [4:0] BRIGHTNESS = 5'h1F,
  parameter int         END_BITS   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [24*LED_CNT-1:0]  data,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   sck,
  output logic                   sda
);

  localparam int SW = 24 * LED_CNT;
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int LW = $clog2(LED_CNT + 1);
  localparam int EW = $clog2(END_BITS + 1);

  typedef enum logic [1:0] {IDLE, START_FRAME, LED_FRAME, END_FRAME} state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic          high;
  logic [4:0]    bit_cnt;
  logic [LW-1:0] led_idx;
  logic [EW-1:0] end_cnt;
  logic [SW-1:0] shadow;

  state_t        nstate;
  logic [4:0]    nbit;
  logic [LW-1:0] nled;
  logic [EW-1:0] nend;
  logic          nval;
  logic          last_bit;
  logic          pix_bit;
  logic          next_pix;

  // Position and value of the bit following the one currently on the wire.
  always_comb begin
    nstate   = state;
    nbit     = bit_cnt + 5'd1;
    nled     = led_idx;
    nend     = end_cnt;
    nval     = 1'b1;
    last_bit = 1'b0;
    pix_bit  = (state == LED_FRAME) && (bit_cnt >= 5'd8);
    // The shadow shifts as each pixel bit finishes, so a following pixel bit is one below the top.
    next_pix = pix_bit ? shadow[SW-2] : shadow[SW-1];
    case (state)
      START_FRAME: begin
        if (bit_cnt == 5'd31) nstate = LED_FRAME;
        else                  nval   = 1'b0;
      end
      LED_FRAME: begin
        if (bit_cnt == 5'd31) begin
          if (led_idx == LW'(LED_CNT - 1)) begin
            nstate = END_FRAME;
            nend   = '0;
          end else begin
            nled = led_idx + 1'b1;
          end
        end else if (nbit < 5'd3) begin
          nval = 1'b1;
        end else if (nbit < 5'd8) begin
          nval = BRIGHTNESS[3'(5'd7 - nbit)];
        end else begin
          nval = next_pix;
        end
      end
      END_FRAME: begin
        nbit = bit_cnt;
        nend = end_cnt + 1'b1;
        if (end_cnt == EW'(END_BITS - 1)) last_bit = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      high    <= 1'b0;
      bit_cnt <= '0;
      led_idx <= '0;
      end_cnt <= '0;
      shadow  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sck     <= 1'b0;
      sda     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state   <= START_FRAME;
          busy    <= 1'b1;
          shadow  <= data;
          sck     <= 1'b0;
          sda     <= 1'b0;
          div_cnt <= '0;
          high    <= 1'b0;
          bit_cnt <= '0;
          led_idx <= '0;
          end_cnt <= '0;
        end
      end else if (div_cnt != DW'(CLK_DIV - 1)) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
        if (!high) begin
          high <= 1'b1;
          sck  <= 1'b1;
        end else begin
          high <= 1'b0;
          sck  <= 1'b0;
          if (pix_bit) shadow <= shadow << 1;
          if (last_bit) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sda   <= 1'b0;
          end else begin
            state   <= nstate;
            bit_cnt <= nbit;
            led_idx <= nled;
            end_cnt <= nend;
            sda     <= nval;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_apa102_out.sv
// Bench for apa102_out: default-parameter instance checked cycle by cycle against a bit-stream
// model, plus a small-parameter instance checked from a table of expected byte streams.
module tb_apa102_out;

  localparam int         LC  = 7;
  localparam int         CD  = 2;
  localparam int         EB  = 32;
  localparam logic [4:0] BR  = 5'h1F;
  localparam int         TOT = 32 + 32 * LC + EB;
  localparam int         CYC = 2 * CD * TOT;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start0, start1;
  logic [24*LC-1:0] data0;
  logic [23:0]     data1;
  logic            busy0, done0, sck0, sda0;
  logic            busy1, done1, sck1, sda1;

  apa102_out dut0 (
    .clk(clk), .rst_n(rst_n), .data(data0), .start(start0),
    .busy(busy0), .done(done0), .sck(sck0), .sda(sda0)
  );

  apa102_out #(.LED_CNT(1), .CLK_DIV(1), .BRIGHTNESS(5'h03), .END_BITS(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .data(data1), .start(start1),
    .busy(busy1), .done(done1), .sck(sck1), .sda(sda1)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit exp_bits[TOT];

  typedef struct {
    logic [23:0] pix;
    logic [71:0] stream;
  } vec_t;

  task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0d: got %h expected %h", name, k, got, exp);
    end
  endtask

  // Reference bit stream: 32 zeros, per pixel {111, brightness, pixel}, then END ones.
  task automatic build_bits(input logic [24*LC-1:0] d);
    int n;
    logic [31:0] fr;
    n = 0;
    for (int i = 0; i < 32; i++) begin exp_bits[n] = 1'b0; n++; end
    for (int p = 0; p < LC; p++) begin
      fr = {3'b111, BR, d[24*(LC-p)-1 -: 24]};
      for (int b = 31; b >= 0; b--) begin exp_bits[n] = fr[b]; n++; end
    end
    for (int e = 0; e < EB; e++) begin exp_bits[n] = 1'b1; n++; end
  endtask

  // Entered at the negedge of the first busy cycle; ends at the negedge of the done cycle.
  task automatic check_stream(input logic [24*LC-1:0] d, input int disturb_k, input int abort_k);
    logic exp_sck;
    build_bits(d);
    for (int k = 0; k < CYC; k++) begin
      exp_sck = ((k % (2 * CD)) >= CD);
      check("stream", k, {28'd0, busy0, done0, sck0, sda0},
            {28'd0, 1'b1, 1'b0, exp_sck, exp_bits[k / (2 * CD)]});
      if (k == abort_k) return;
      if (disturb_k >= 0 && k == disturb_k) begin
        start0 = 1'b1;
        data0  = {LC{24'hAAAAAA}};
      end
      if (disturb_k >= 0 && k == disturb_k + 1) start0 = 1'b0;
      @(negedge clk);
    end
    check("done_cycle", 0, {28'd0, busy0, done0, sck0, sda0}, 32'h4);
  endtask

  task automatic start_xfer(input logic [24*LC-1:0] d);
    @(negedge clk);
    data0  = d;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic check_idle0();
    @(negedge clk);
    check("idle", 0, {28'd0, busy0, done0, sck0, sda0}, 32'h0);
  endtask

  function automatic logic [24*LC-1:0] rand_data();
    logic [24*LC-1:0] d;
    for (int p = 0; p < LC; p++) d[24*p +: 24] = 24'($urandom);
    return d;
  endfunction

  initial begin
    vec_t             tbl[4];
    logic [24*LC-1:0] d;
    logic [71:0]      got_stream;
    int               nbits, nbusy, seen, prev_sck, cyc, rise0, rise1;

    tbl[0] = '{24'h123456, 72'h00000000_E3_123456_FF};
    tbl[1] = '{24'h000000, 72'h00000000_E3_000000_FF};
    tbl[2] = '{24'hFFFFFF, 72'h00000000_E3_FFFFFF_FF};
    tbl[3] = '{24'hA5C3E1, 72'h00000000_E3_A5C3E1_FF};

    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; data0 = '0; data1 = '0;
    repeat (2) @(negedge clk);
    check("reset0", 0, {28'd0, busy0, done0, sck0, sda0}, 32'h0);
    check("reset1", 0, {28'd0, busy1, done1, sck1, sda1}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Small instance: table of expected byte streams.
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      data1  = tbl[t].pix;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      got_stream = '0; nbits = 0; nbusy = 0; seen = 0; prev_sck = 0; cyc = 0; rise0 = -1; rise1 = -1;
      while (cyc < 400 && seen == 0) begin
        if (busy1) nbusy++;
        if (done1) begin
          seen = 1;
          check("small_done_outs", t, {29'd0, busy1, sck1, sda1}, 32'h0);
        end else begin
          if (sck1 && prev_sck == 0) begin
            got_stream = {got_stream[70:0], sda1};
            nbits++;
            if (rise0 < 0) rise0 = cyc;
            else if (rise1 < 0) rise1 = cyc;
          end
          prev_sck = int'(sck1);
          cyc++;
          @(negedge clk);
        end
      end
      check("small_done_seen", t, 32'(seen), 32'd1);
      check("small_stream_hi", t, got_stream[71:40], tbl[t].stream[71:40]);
      check("small_stream_lo", t, got_stream[39:8], tbl[t].stream[39:8]);
      check("small_stream_end", t, {24'd0, got_stream[7:0]}, {24'd0, tbl[t].stream[7:0]});
      check("small_nbits", t, 32'(nbits), 32'd72);
      check("small_busy_cycles", t, 32'(nbusy), 32'd144);
      check("small_sck_period", t, 32'(rise1 - rise0), 32'd2);
    end

    // Single pixel lit red-channel byte, others dark.
    d = {24'hFF0000, {6{24'h000000}}};
    start_xfer(d);
    check_stream(d, -1, -1);
    check_idle0();

    // Randomized pixel payloads.
    for (int r = 0; r < 3; r++) begin
      d = rand_data();
      start_xfer(d);
      check_stream(d, -1, -1);
      check_idle0();
    end

    // Start pulse and new data mid-transfer must be ignored.
    d = rand_data();
    start_xfer(d);
    check_stream(d, 500, -1);
    check_idle0();

    // Start held high: back-to-back transfers separated by the done cycle.
    @(negedge clk);
    d      = rand_data();
    data0  = d;
    start0 = 1'b1;
    @(negedge clk);
    check_stream(d, -1, -1);
    @(negedge clk);
    check_stream(d, -1, -1);
    start0 = 1'b0;
    check_idle0();

    // Asynchronous reset during an LED frame while sck is high.
    d = rand_data();
    start_xfer(d);
    check_stream(d, -1, 258);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 0, {28'd0, busy0, done0, sck0, sda0}, 32'h0);
    @(negedge clk);
    check("reset_no_done", 0, {28'd0, busy0, done0, sck0, sda0}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_reset", 0, {28'd0, busy0, done0, sck0, sda0}, 32'h0);
    d = rand_data();
    start_xfer(d);
    check_stream(d, -1, -1);
    check_idle0();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
